// File: rtl/rect_fill_engine_pkg.sv
// Shared definitions for the rectangle-fill engine: geometry defaults,
// FSM state encoding and the coordinate clamp helper.
package rect_fill_engine_pkg;

  localparam int unsigned H_RES_DEF      = 640;
  localparam int unsigned V_RES_DEF      = 480;
  localparam int unsigned ADDR_WIDTH_DEF = 19;

  // Internal coordinate width; rows are carried at column width so one
  // clamp helper and one comparator style serve both axes.
  localparam int unsigned COORD_W = 10;
  localparam int unsigned ROW_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // Saturate a coordinate to the last valid column/row.
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] i_val,
    input logic [COORD_W-1:0] i_lim
  );
    return (i_val > i_lim) ? i_lim : i_val;
  endfunction

endpackage

// File: rtl/rect_fill_engine_pixel_port_mux.sv
// Pixel-port ownership mux: hands DPRAM port 0 either to the processor
// (pass-through) or to the fill engine.
module rect_fill_engine_pixel_port_mux #(
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  i_sel_engine,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic                  i_cpu_data,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_eng_addr,
  input  logic                  i_eng_data,
  input  logic                  i_eng_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_data,
  output logic                  o_we
);

  // Select the owning bundle; processor writes vanish while the engine owns the port.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    o_addr = i_cpu_addr;
    o_data = i_cpu_data;
    o_we   = i_cpu_we;
    if (i_sel_engine) begin
      o_addr = i_eng_addr;
      o_data = i_eng_data;
      o_we   = i_eng_we;
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle-fill writer in front of the 1-bit frame-buffer DPRAM port 0.
// Accepts one command, clamps it to the screen, then writes one pixel per
// clock row by row; idle time passes the processor's pixel port through.
module rect_fill_engine
  import rect_fill_engine_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  CPU_RESETN,
  input  logic                  start,
  input  logic [COORD_W-1:0]    x0,
  input  logic [ROW_W-1:0]      y0,
  input  logic [COORD_W-1:0]    x1,
  input  logic [ROW_W-1:0]      y1,
  input  logic                  color,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] cpu_pixel_addr,
  input  logic                  cpu_pixel_in,
  input  logic                  cpu_pixel_we,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic                  pixel_in,
  output logic                  pixel_we
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] ROW_PAD = '0;

  fill_state_t r_state;
  fill_state_t w_next_state;

  logic [COORD_W-1:0]    r_x0, r_x1, r_y0, r_y1;
  logic [COORD_W-1:0]    r_col, r_row;
  logic                  r_color;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_row_base;

  logic [COORD_W-1:0]    w_y0_wide, w_y1_wide;
  logic                  w_reject;
  logic                  w_col_more, w_row_more;
  logic [ADDR_WIDTH-1:0] w_x0_ext, w_y0_ext;
  logic [ADDR_WIDTH-1:0] w_row_base0;
  logic [ADDR_WIDTH-1:0] w_next_row_base;

  assign w_y0_wide  = {ROW_PAD[COORD_W-1:ROW_W], y0};
  assign w_y1_wide  = {ROW_PAD[COORD_W-1:ROW_W], y1};
  assign w_reject   = (r_x0 > r_x1) || (r_y0 > r_y1);
  assign w_col_more = (r_col < r_x1);
  assign w_row_more = (r_row < r_y1);
  assign w_x0_ext   = ADDR_WIDTH'(r_x0);
  assign w_y0_ext   = ADDR_WIDTH'(r_y0);
  assign w_next_row_base = r_row_base + ADDR_WIDTH'(H_RES);

  // The default 640-pixel stride is 512+128, so the first row base is two
  // shifts and an add rather than a multiplier.
  generate
    if (H_RES == 640) begin : g_row_base_shift
      assign w_row_base0 = (w_y0_ext << 9) + (w_y0_ext << 7);
    end else begin : g_row_base_mult
      assign w_row_base0 = w_y0_ext * ADDR_WIDTH'(H_RES);
    end
  endgenerate

  // State register; reset abandons any fill in progress immediately.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> SETUP -> FILL -> DONE -> IDLE, with rejects skipping FILL.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SETUP;
      ST_SETUP: w_next_state = w_reject ? ST_DONE : ST_FILL;
      ST_FILL:  if (!w_col_more && !w_row_more) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Command latch and raster address generation.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_color    <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_row_base <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x0    <= clamp_coord(x0, X_LIM);
            r_x1    <= clamp_coord(x1, X_LIM);
            r_y0    <= clamp_coord(w_y0_wide, Y_LIM);
            r_y1    <= clamp_coord(w_y1_wide, Y_LIM);
            r_color <= color;
          end
        end
        ST_SETUP: begin
          r_row_base <= w_row_base0;
          r_addr     <= w_row_base0 + w_x0_ext;
          r_col      <= r_x0;
          r_row      <= r_y0;
        end
        ST_FILL: begin
          if (w_col_more) begin
            r_col  <= r_col + 1'b1;
            r_addr <= r_addr + 1'b1;
          end else if (w_row_more) begin
            r_row      <= r_row + 1'b1;
            r_col      <= r_x0;
            r_row_base <= w_next_row_base;
            r_addr     <= w_next_row_base + w_x0_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

  rect_fill_engine_pixel_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_mux (
    .i_sel_engine (busy),
    .i_cpu_addr   (cpu_pixel_addr),
    .i_cpu_data   (cpu_pixel_in),
    .i_cpu_we     (cpu_pixel_we),
    .i_eng_addr   (r_addr),
    .i_eng_data   (r_color),
    .i_eng_we     (r_state == ST_FILL),
    .o_addr       (pixel_addr),
    .o_data       (pixel_in),
    .o_we         (pixel_we)
  );

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: table of fill commands plus
// randomized commands, all checked against a raster-scan reference model.
module tb_rect_fill_engine;

  typedef int int_q_t[$];

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
    int color;
    int cpu_noise;
    int start_noise;
    int exp_cnt;
    int exp_first;
    int exp_last;
  } vec_t;

  logic        clk;
  logic        CPU_RESETN;
  logic        start;
  logic [9:0]  x0, x1;
  logic [8:0]  y0, y1;
  logic        color;
  logic        busy, done;
  logic [18:0] cpu_pixel_addr;
  logic        cpu_pixel_in;
  logic        cpu_pixel_we;
  logic [18:0] pixel_addr;
  logic        pixel_in;
  logic        pixel_we;

  int checks = 0;
  int errors = 0;

  rect_fill_engine dut (
    .clk            (clk),
    .CPU_RESETN     (CPU_RESETN),
    .start          (start),
    .x0             (x0),
    .y0             (y0),
    .x1             (x1),
    .y1             (y1),
    .color          (color),
    .busy           (busy),
    .done           (done),
    .cpu_pixel_addr (cpu_pixel_addr),
    .cpu_pixel_in   (cpu_pixel_in),
    .cpu_pixel_we   (cpu_pixel_we),
    .pixel_addr     (pixel_addr),
    .pixel_in       (pixel_in),
    .pixel_we       (pixel_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every on-screen pixel of the clamped rectangle, row-major.
  task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1,
                           output int_q_t q);
    int cx0, cy0, cx1, cy1;
    cx0 = (ax0 > 639) ? 639 : ax0;
    cx1 = (ax1 > 639) ? 639 : ax1;
    cy0 = (ay0 > 479) ? 479 : ay0;
    cy1 = (ay1 > 479) ? 479 : ay1;
    q = {};
    if (cx0 > cx1 || cy0 > cy1) return;
    for (int y = cy0; y <= cy1; y++)
      for (int x = cx0; x <= cx1; x++)
        q.push_back(y * 640 + x);
  endtask

  // Issue one command and compare the full write stream and its timing.
  task automatic run_cmd(input string tag,
                         input int ax0, input int ay0, input int ax1, input int ay1,
                         input int acol, input int cpu_noise, input int start_noise,
                         output int n_wr, output int first_addr, output int last_addr);
    int_q_t exp;
    int     first_k, done_k, n_bad, k, budget, busy_at_done;
    int     ax0_v, ay0_v, ax1_v, ay1_v;
    build_exp(ax0, ay0, ax1, ay1, exp);
    budget = exp.size() + 10;
    first_k = -1; done_k = -1; n_bad = 0; n_wr = 0; busy_at_done = 0;
    first_addr = -1; last_addr = -1;
    ax0_v = ax0; ay0_v = ay0; ax1_v = ax1; ay1_v = ay1;
    @(negedge clk);
    x0 = ax0_v[9:0]; y0 = ay0_v[8:0]; x1 = ax1_v[9:0]; y1 = ay1_v[8:0];
    color = acol[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    forever begin
      if (pixel_we) begin
        if (first_k < 0) begin
          first_k = k;
          first_addr = int'(pixel_addr);
        end
        last_addr = int'(pixel_addr);
        if (n_wr >= exp.size()) n_bad++;
        else if (int'(pixel_addr) != exp[n_wr] || pixel_in !== acol[0]) n_bad++;
        n_wr++;
      end
      if (done) begin
        done_k = k;
        busy_at_done = int'(busy);
        break;
      end
      if (k >= budget) break;
      cpu_pixel_we = cpu_noise[0];
      start = (start_noise != 0) && (k == 2);
      if (start) begin
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd7; y1 = 9'd7;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    cpu_pixel_we = 1'b0;
    check({tag, " write count"}, n_wr, exp.size());
    check({tag, " bad writes"}, n_bad, 0);
    check({tag, " first write cycle"}, first_k, (exp.size() > 0) ? 2 : -1);
    check({tag, " done cycle"}, done_k, 2 + exp.size());
    check({tag, " busy at done"}, busy_at_done, 1);
    @(negedge clk);
    check({tag, " busy after done"}, int'(busy), 0);
    check({tag, " done one cycle"}, int'(done), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int n_wr, fa, la, n;
    int rx0, ry0, rx1, ry1;

    // Table: corners, colour, noise flags, expected count/first/last address.
    vecs[0] = '{1, 1, 2, 2, 1, 1, 0, 4, 641, 1282};
    vecs[1] = '{630, 470, 700, 500, 1, 0, 1, 100, 301430, 307199};
    vecs[2] = '{10, 0, 5, 3, 1, 1, 0, 0, -1, -1};
    vecs[3] = '{0, 10, 3, 2, 1, 0, 0, 0, -1, -1};
    vecs[4] = '{0, 0, 639, 9, 0, 1, 1, 6400, 0, 6399};
    vecs[5] = '{0, 0, 0, 479, 1, 0, 1, 480, 0, 306560};
    vecs[6] = '{5, 5, 5, 5, 1, 0, 1, 1, 3205, 3205};

    // Reset: engine idle, port in pass-through.
    CPU_RESETN = 1'b0;
    start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = 1'b0;
    cpu_pixel_addr = 19'd777;
    cpu_pixel_in = 1'b1;
    cpu_pixel_we = 1'b1;
    #3;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset pass we", int'(pixel_we), 1);
    check("reset pass addr", int'(pixel_addr), 777);
    cpu_pixel_we = 1'b0;
    #1;
    check("reset pass we low", int'(pixel_we), 0);
    repeat (2) @(negedge clk);
    CPU_RESETN = 1'b1;

    // Idle pass-through is combinational.
    @(negedge clk);
    cpu_pixel_addr = 19'd12345;
    cpu_pixel_in = 1'b0;
    cpu_pixel_we = 1'b1;
    #1;
    check("idle pass we", int'(pixel_we), 1);
    check("idle pass addr", int'(pixel_addr), 12345);
    check("idle pass data", int'(pixel_in), 0);
    cpu_pixel_we = 1'b0;
    // Out-of-range CPU address so any leak during a fill breaks the stream.
    cpu_pixel_addr = 19'h7FFFF;
    cpu_pixel_in = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
              vecs[i].color, vecs[i].cpu_noise, vecs[i].start_noise, n_wr, fa, la);
      check($sformatf("vec%0d table count", i), n_wr, vecs[i].exp_cnt);
      if (vecs[i].exp_cnt > 0) begin
        check($sformatf("vec%0d first addr", i), fa, vecs[i].exp_first);
        check($sformatf("vec%0d last addr", i), la, vecs[i].exp_last);
      end
    end

    // Randomized commands, some deliberately inverted to exercise rejection.
    for (int i = 0; i < 10; i++) begin
      rx0 = $urandom_range(0, 700);
      ry0 = $urandom_range(0, 500);
      rx1 = rx0 + $urandom_range(0, 25) - 3;
      ry1 = ry0 + $urandom_range(0, 25) - 3;
      if (rx1 < 0) rx1 = 0;
      if (ry1 < 0) ry1 = 0;
      if (rx1 > 1023) rx1 = 1023;
      if (ry1 > 511) ry1 = 511;
      run_cmd($sformatf("rand%0d", i), rx0, ry0, rx1, ry1, $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), n_wr, fa, la);
    end

    // Reset in the middle of a 4x4 fill.
    @(negedge clk);
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd3; y1 = 9'd3; color = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (pixel_we) n++;
      if (n == 3) break;
      @(negedge clk);
    end
    check("midreset writes seen", n, 3);
    #2;
    CPU_RESETN = 1'b0;
    #1;
    check("midreset busy async", int'(busy), 0);
    check("midreset we async", int'(pixel_we), 0);
    cpu_pixel_we = 1'b1;
    #1;
    check("midreset pass we", int'(pixel_we), 1);
    cpu_pixel_we = 1'b0;
    @(negedge clk);
    CPU_RESETN = 1'b1;
    @(negedge clk);
    check("post reset busy", int'(busy), 0);
    check("post reset we", int'(pixel_we), 0);
    run_cmd("after reset 1x1", 0, 0, 0, 0, 1, 0, 0, n_wr, fa, la);
    check("after reset single write", n_wr, 1);
    check("after reset addr", fa, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Hardware rectangle-fill writer that sits directly upstream of the 640x480, 1-bit pixel DPRAM and drives its port 0.
- The processor issues one fill command (corners plus colour) and the engine writes every enclosed pixel at one pixel per clock.
- When idle, the engine passes the processor's own pixel-port signals through to the DPRAM unchanged.

Parameters:
H_RES, 640, pixels per row; also the address stride between rows.
V_RES, 480, number of rows.
ADDR_WIDTH, 19, DPRAM address width.

Ports:
clk  in  1  system (divided) clock; all logic on its rising edge
CPU_RESETN  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe, sampled only in IDLE
x0  in  10  left column, inclusive
y0  in  9  top row, inclusive
x1  in  10  right column, inclusive
y1  in  9  bottom row, inclusive
color  in  1  fill value
busy  out  1  high from the cycle after an accepted start through the DONE state
done  out  1  one-cycle pulse at command completion, including rejected commands
cpu_pixel_addr  in  ADDR_WIDTH  processor pixel address
cpu_pixel_in  in  1  processor write data
cpu_pixel_we  in  1  processor write enable
pixel_addr  out  ADDR_WIDTH  to DPRAM addr0
pixel_in  out  1  to DPRAM dataIn0
pixel_we  out  1  to DPRAM wEn0

Behaviour:
- Reset, asynchronous and asserted while CPU_RESETN=0:
  - state=IDLE; busy=0, done=0.
  - All internal counters cleared.
  - Output mux is in pass-through, so pixel_we follows cpu_pixel_we combinationally.
  - Reset mid-fill abandons the fill immediately. No further engine writes occur; pixels already written remain.
- States: IDLE -> SETUP -> FILL -> DONE -> IDLE.
- IDLE:
  - pixel_addr/pixel_in/pixel_we = cpu_pixel_* (combinational pass-through).
  - On start=1: latch the command. Clamp x0,x1 to H_RES-1 and y0,y1 to V_RES-1. Go to SETUP.
- SETUP (1 cycle):
  - Engine owns the port; pixel_we=0.
  - If clamped x0>x1 or y0>y1, the command is rejected: go to DONE with no writes.
  - Otherwise row_base = y0*H_RES computed as (y0<<9)+(y0<<7) for the default; no multiplier.
  - Load addr=row_base+x0, col=x0, row=y0.
- FILL (1 pixel per cycle):
  - pixel_we=1, pixel_addr=addr, pixel_in=color.
  - If col<x1: col++, addr++.
  - Else if row<y1: row++, col=x0, row_base+=H_RES, addr=row_base+H_RES+x0.
  - Else go to DONE.
- DONE (1 cycle): pixel_we=0, done=1, busy still 1. Next cycle returns to IDLE.
- Latency:
  - Start accepted at edge N; first write presented in cycle N+2.
  - A W x H fill occupies W*H FILL cycles; done is high in the cycle after the last write.
- Port ownership:
  - In SETUP, FILL and DONE, cpu_pixel_we is ignored; processor writes are silently dropped.
  - Software must poll busy before direct writes.
- start while busy is ignored and not queued.
- Arithmetic: addr and row_base are ADDR_WIDTH unsigned. Maximum address H_RES*V_RES-1 = 307199, so no wrap-around is possible after clamping.
- Coordinates are unsigned; no negative handling.

Decomposition:
- Shared package holds:
  - H_RES, V_RES and ADDR_WIDTH defaults.
  - The state encoding (IDLE=0, SETUP=1, FILL=2, DONE=3).
  - A clamp helper function.
- The pass-through/ownership mux is a natural single sub-module, pixel_port_mux: a select line plus two pixel-port bundles in and one out.
- Address generation stays inline in the FSM.

Test Plan:
- Fill (1,1)-(2,2), color=1, start at edge N → writes at addr 641, 642, 1281, 1282 in cycles N+2..N+5; done=1 in cycle N+6; busy low at N+7.
- Full-screen clear (0,0)-(639,479), color=0 → exactly 307200 writes; first addr 0, last addr 307199; done follows immediately; no address repeats or gaps.
- Clamp: (630,470)-(700,500) → writes cover x 630..639, y 470..479 (100 writes); last addr 307199.
- Reject: x0=10, x1=5 → no pixel_we assertion; done pulses in cycle N+2.
- Pass-through: idle with cpu_pixel_we=1, addr=12345 → pixel_we=1, pixel_addr=12345 the same cycle. During a fill, cpu_pixel_we=1 → no CPU address appears on pixel_addr.
- Reset mid-fill: assert CPU_RESETN=0 after 3 writes of a 4x4 fill → pixel_we and busy drop asynchronously. After release, the engine is IDLE and a fresh 1x1 command at (0,0) writes addr 0 only.
